// File: rtl/spi_flash_rd_if.sv
// Request/response handshake plus SPI pins of spi_flash_rd; master = requester side, slave = the reader.
interface spi_flash_rd_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        spi_cs;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output req_valid, req_addr, spi_miso,
        input  req_ready, rsp_valid, rsp_data, spi_cs, spi_clk, spi_mosi
    );

    modport slave (
        input  req_valid, req_addr, spi_miso,
        output req_ready, rsp_valid, rsp_data, spi_cs, spi_clk, spi_mosi
    );
endinterface

// File: rtl/spi_flash_rd.sv
// SPI mode-0 single-word flash reader; SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B + 8 dummy bits).
// rsp_valid pulses 1+2*CLK_DIV*N cycles after accept (N=64/72), no rsp backpressure, req_ready only in IDLE.
module spi_flash_rd #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h500000
) (
    input  logic          clk,
    input  logic          rst,
    spi_flash_rd_if.slave bus
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0]  CMD_BYTE = 8'h0B;
    localparam int unsigned N_BITS   = 72;
`else
    localparam logic [7:0]  CMD_BYTE = 8'h03;
    localparam int unsigned N_BITS   = 64;
`endif
    localparam logic [8:0] HALF_M1  = 9'(CLK_DIV - 1);
    localparam logic [8:0] DONE_M1  = 9'(2 * CLK_DIV - 1);
    localparam logic [6:0] LAST_BIT = 7'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_cs_n;
    logic        r_sck;
    logic        r_mosi;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic [8:0]  r_div_cnt;
    logic [6:0]  r_bit_cnt;

    logic [23:0] w_flash_addr;
    logic [6:0]  w_bit_nxt;
    state_t      w_bit_state;
    logic        w_bit_is_tx;

    assign w_flash_addr = FLASH_BASE + bus.req_addr;
    assign w_bit_nxt    = r_bit_cnt + 7'd1;

    // Phase owning the next bit, derived from its position in the frame.
    always_comb begin
        w_bit_state = S_DATA;
        if (w_bit_nxt < 7'd8) begin
            w_bit_state = S_CMD;
        end else if (w_bit_nxt < 7'd32) begin
            w_bit_state = S_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
        end else if (w_bit_nxt < 7'd40) begin
            w_bit_state = S_DUMMY;
`endif
        end
    end

    assign w_bit_is_tx = (w_bit_state == S_CMD) || (w_bit_state == S_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_tx        <= 32'd0;
            r_rx        <= 32'd0;
            r_div_cnt   <= 9'd0;
            r_bit_cnt   <= 7'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (bus.req_valid && r_ready) begin
                        r_ready   <= 1'b0;
                        r_state   <= S_CMD;
                        r_tx      <= {CMD_BYTE, w_flash_addr};
                        r_div_cnt <= 9'd0;
                        r_bit_cnt <= 7'd0;
                    end
                end
                S_DONE: begin
                    if (r_div_cnt == DONE_M1) begin
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b1;
                        r_div_cnt <= 9'd0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 9'd1;
                    end
                end
                default: begin
                    // First CMD cycle only asserts CS and presents bit 7; bit timing starts after it.
                    if (r_cs_n) begin
                        r_cs_n    <= 1'b0;
                        r_mosi    <= r_tx[31];
                        r_div_cnt <= 9'd0;
                    end else if (r_div_cnt != HALF_M1) begin
                        r_div_cnt <= r_div_cnt + 9'd1;
                    end else begin
                        r_div_cnt <= 9'd0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            if (r_state == S_DATA) begin
                                r_rx <= {r_rx[30:0], bus.spi_miso};
                            end
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state     <= S_DONE;
                                r_cs_n      <= 1'b1;
                                r_mosi      <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                            end else begin
                                r_bit_cnt <= w_bit_nxt;
                                r_state   <= w_bit_state;
                                r_tx      <= {r_tx[30:0], 1'b0};
                                r_mosi    <= w_bit_is_tx ? r_tx[30] : 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.spi_cs    = r_cs_n;
    assign bus.spi_clk   = r_sck;
    assign bus.spi_mosi  = r_mosi;

endmodule

// File: tb/tb_spi_flash_rd.sv
// Scoreboard bench: instance 0 uses CLK_DIV=2, instance 1 CLK_DIV=1; a flash model per instance.
module tb_spi_flash_rd;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam int         N   = 72;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam int         N   = 64;
`endif
    localparam int HDR  = N - 32;
    localparam int LAT2 = 4 * N + 1;
    localparam int LAT1 = 2 * N + 1;

    typedef struct packed {
        logic [7:0]  inst;
        logic [31:0] data;
        logic [31:0] hdr;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic [23:0] req_addr   [2];
    logic [31:0] flash_word [2];

    wire         req_ready [2];
    wire         rsp_valid [2];
    wire  [31:0] rsp_data  [2];
    wire         spi_cs    [2];
    wire         spi_clk   [2];
    wire         spi_mosi  [2];
    wire  [31:0] cap_w     [2];
    wire         bad_w     [2];
    wire  [31:0] last_hi_w [2];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   last_t0 = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_flash_rd_if bus ();
        logic        miso = 1'b0;
        logic        prev_sck = 1'b0;
        logic        prev_mosi = 1'b0;
        logic        bad = 1'b0;
        logic [31:0] cap = 32'd0;
        logic [31:0] dsh = 32'd0;
        int          nbits = 0;
        int          hi_run = 0;
        int          last_hi = 0;

        assign bus.req_valid = req_valid[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.spi_miso  = miso;
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_data[g]   = bus.rsp_data;
        assign spi_cs[g]     = bus.spi_cs;
        assign spi_clk[g]    = bus.spi_clk;
        assign spi_mosi[g]   = bus.spi_mosi;
        assign cap_w[g]      = cap;
        assign bad_w[g]      = bad;
        assign last_hi_w[g]  = 32'(last_hi);

        spi_flash_rd #(.CLK_DIV(g == 0 ? 2 : 1), .FLASH_BASE(24'h500000)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Flash model: captures cmd+addr on SCK rise, shifts data out after SCK fall.
        initial forever begin
            @(negedge clk);
            if (bus.spi_cs) begin
                if (bus.spi_mosi) bad = 1'b1;
                nbits = 0;
                miso  = 1'b0;
                dsh   = flash_word[g];
                hi_run++;
            end else begin
                if (hi_run > 0) last_hi = hi_run;
                hi_run = 0;
                if (bus.spi_clk && prev_sck && (bus.spi_mosi != prev_mosi)) bad = 1'b1;
                if (!bus.spi_clk && nbits >= 32 && bus.spi_mosi) bad = 1'b1;
                if (bus.spi_clk && !prev_sck) begin
                    if (nbits < 32) cap = {cap[30:0], bus.spi_mosi};
                    nbits++;
                end else if (!bus.spi_clk && prev_sck && nbits >= 32) begin
                    if (nbits < HDR) begin
                        miso = 1'b1;
                    end else begin
                        miso = dsh[31];
                        dsh  = {dsh[30:0], 1'b0};
                    end
                end
            end
            prev_sck  = bus.spi_clk;
            prev_mosi = bus.spi_mosi;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rsp_valid pops one expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid[i]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_instance", 32'(i), 32'(e.inst));
                    chk("rsp_data", rsp_data[i], e.data);
                    chk("rsp_cycle", 32'(cyc), e.due);
                    chk("mosi_cmd_addr", cap_w[i], e.hdr);
                    chk("mosi_rules", 32'(bad_w[i]), 32'd0);
                end
            end
        end
    end

    task automatic issue(input int i, input logic [23:0] a, input logic [31:0] word,
                         input logic [31:0] hdr, input logic [31:0] data, input int lat,
                         input bit want_rsp, input bit keep, input int exp_t0);
        int n = 0;
        @(negedge clk);
        flash_word[i] = word;
        req_valid[i]  = 1'b1;
        req_addr[i]   = a;
        while (!req_ready[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_seen", 32'(req_ready[i]), 32'd1);
        last_t0 = cyc + 1;
        if (exp_t0 >= 0) chk("accept_cycle", 32'(last_t0), 32'(exp_t0));
        if (want_rsp) exp_q.push_back(exp_t'{8'(i), data, hdr, 32'(last_t0 + lat)});
        @(negedge clk);
        req_addr[i] = ~a;
        if (!keep) req_valid[i] = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = 24'd0;
            flash_word[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_spi_cs", 32'(spi_cs[i]), 32'd1);
            chk("rst_spi_clk", 32'(spi_clk[i]), 32'd0);
            chk("rst_spi_mosi", 32'(spi_mosi[i]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_rsp_data", rsp_data[i], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready[0]), 32'd1);

        issue(0, 24'h000010, 32'hEFBEADDE, {CMD, 24'h500010}, 32'hDEADBEEF, LAT2, 1'b1, 1'b0, -1);
        wait_done();
        issue(0, 24'hB00004, 32'h11223344, {CMD, 24'h000004}, 32'h44332211, LAT2, 1'b1, 1'b0, -1);
        wait_done();
        issue(0, 24'h123456, 32'h0F1E2D3C, {CMD, 24'h623456}, 32'h3C2D1E0F, LAT2, 1'b1, 1'b0, -1);
        wait_done();

        issue(0, 24'h000100, 32'hA5C35A3C, {CMD, 24'h500100}, 32'h3C5AC3A5, LAT2, 1'b1, 1'b1, -1);
        t1 = last_t0;
        issue(0, 24'hFFFFFC, 32'h01020304, {CMD, 24'h4FFFFC}, 32'h04030201, LAT2, 1'b1, 1'b0,
              t1 + LAT2 + 5);
        wait_done();
        chk("cs_high_gap", last_hi_w[0], 32'd6);

        // Abort during an address bit's SCK-high phase (bit 12).
        issue(0, 24'h000030, 32'hFFFFFFFF, 32'd0, 32'd0, LAT2, 1'b0, 1'b0, -1);
        while (cyc < last_t0 + 51) @(negedge clk);
        chk("sck_high_before_abort", 32'(spi_clk[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_spi_cs", 32'(spi_cs[0]), 32'd1);
        chk("abort_spi_clk", 32'(spi_clk[0]), 32'd0);
        chk("abort_spi_mosi", 32'(spi_mosi[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
        chk("abort_rsp_data", rsp_data[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(0, 24'h000020, 32'h5A6B7C8D, {CMD, 24'h500020}, 32'h8D7C6B5A, LAT2, 1'b1, 1'b0, -1);
        wait_done();

        issue(1, 24'h000010, 32'h80000001, {CMD, 24'h500010}, 32'h01000080, LAT1, 1'b1, 1'b0, -1);
        wait_done();
        issue(1, 24'hAFFFFF, 32'hC0FFEE00, {CMD, 24'hFFFFFF}, 32'h00EEFFC0, LAT1, 1'b1, 1'b0, -1);
        wait_done();

        chk("final_mosi_rules_0", 32'(bad_w[0]), 32'd0);
        chk("final_mosi_rules_1", 32'(bad_w[1]), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_rd.md
SPI_FLASH_RD -- requirements
Module: spi_flash_rd

Interface
- REQ-001 The block SHALL have parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
- REQ-002 The block SHALL have parameter FLASH_BASE, default 24'h500000: byte offset added to every request address.
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic.
- REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-005 The block SHALL have port req_valid, input, 1 bit: read request present.
- REQ-006 The block SHALL have port req_ready, output, 1 bit: block idle, request accepted when req_valid && req_ready at a clk rising edge.
- REQ-007 The block SHALL have port req_addr, input, 24 bits: word byte address, sampled only at accept.
- REQ-008 The block SHALL have port rsp_valid, output, 1 bit: one-cycle pulse, rsp_data valid.
- REQ-009 The block SHALL have port rsp_data, output, 32 bits: read word, held until next rsp_valid.
- REQ-010 The block SHALL have port spi_cs, output, 1 bit: flash chip select, active-low.
- REQ-011 The block SHALL have port spi_clk, output, 1 bit: SCK, mode 0, idles low.
- REQ-012 The block SHALL have port spi_mosi, output, 1 bit: command/address out.
- REQ-013 The block SHALL have port spi_miso, input, 1 bit: flash data in.

Function
- REQ-014 The FSM SHALL have states IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (8 bits, FAST_READ only), DATA (32 bits), DONE; req_ready SHALL be 1 only in IDLE.
- REQ-015 On accept at edge T0, the block SHALL drive spi_cs low and spi_mosi with command bit 7 from T0+1, and enter CMD.
- REQ-016 Each SPI bit SHALL last 2*CLK_DIV clk cycles: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles; MOSI SHALL change only while SCK is low; MISO SHALL be sampled on the clk edge where SCK goes high.
- REQ-017 The command byte SHALL be 0x03, the address SHALL be (FLASH_BASE + req_addr) mod 2^24, and both SHALL be sent MSB first.
- REQ-018 DATA SHALL receive 4 bytes, MSB first within each byte; byte n (n = 0..3, first received = 0) SHALL land in rsp_data[8n+7:8n] (little-endian).
- REQ-019 After the final SCK high phase, the block SHALL drive SCK low and spi_cs high and pulse rsp_valid for exactly one cycle, at T0+1+2*CLK_DIV*N, where N = 64 for normal read and 72 for FAST_READ.
- REQ-020 DONE SHALL last 2*CLK_DIV cycles, then return to IDLE; minimum spi_cs high time SHALL be 2*CLK_DIV+2 cycles.
- REQ-021 rsp_valid SHALL have no backpressure; req_valid SHALL be ignored outside IDLE, and req_addr changes after accept SHALL have no effect.
- REQ-022 spi_mosi SHALL be 0 whenever spi_cs is high or during DUMMY/DATA.

Reset
- REQ-023 While rst is high, the block SHALL asynchronously force: state IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_data=0, req_ready=0.
- REQ-024 req_ready SHALL rise on the first clk edge after rst deasserts.
- REQ-025 Reset mid-transfer SHALL abort the transfer with no rsp_valid, and the next request SHALL run a complete fresh transaction.

Configuration
- REQ-026 When macro SPI_FLASH_FAST_READ_EN is defined, the command SHALL be 0x0B and 8 DUMMY bits (MOSI=0, MISO ignored) SHALL follow ADDR, giving N=72.
- REQ-027 When SPI_FLASH_FAST_READ_EN is undefined, the command SHALL be 0x03, no DUMMY state SHALL exist in the logic, and N=64.

Verification
- REQ-028 Basic read: CLK_DIV=2, FLASH_BASE=0x500000, req_addr=0x000010, flash model returns EF BE AD DE -> MOSI = 03 50 00 10, rsp_data=0xDEADBEEF, rsp_valid at T0+257.
- REQ-029 Fast read: SPI_FLASH_FAST_READ_EN defined, same stimulus -> MOSI = 0B 50 00 10 followed by 8 zero bits, rsp_valid at T0+289.
- REQ-030 Address wrap: req_addr=0xB00004 -> transmitted address 0x000004.
- REQ-031 Back-to-back: req_valid held high for two requests -> second accept 5 cycles after the first rsp_valid, and spi_cs high for 6 cycles between transactions.
- REQ-032 Reset mid-ADDR: rst pulsed during ADDR -> spi_cs=1 and spi_clk=0 in the same cycle, no rsp_valid, and a following request for 0x000020 completes correctly.
- REQ-033 Divider: CLK_DIV=1 -> SCK period of 2 cycles, rsp_valid at T0+129, and data correct.
